// File: rtl/branch_pkg.sv
// Shared definitions for the branch condition unit.
// Condition codes, FSM state encoding and statistics counter width.
package branch_pkg;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_RESOLVE = 2'd2
   } state_t;

   localparam int STAT_WIDTH = 16;

endpackage

// File: rtl/cond_evaluator.sv
// Combinational ARM condition-code check against N/Z/C/V.
// Kept standalone so predicated execution can reuse it.
module cond_evaluator
   import branch_pkg::*;
(
   input  logic [3:0] cond,
   input  logic       n,
   input  logic       z,
   input  logic       c,
   input  logic       v,
   output logic       pass
);

   // Decode the condition code into a pass/fail decision
   always_comb begin
      pass = 1'b0;
      unique case (cond)
         COND_EQ: pass = z;
         COND_NE: pass = !z;
         COND_CS: pass = c;
         COND_CC: pass = !c;
         COND_MI: pass = n;
         COND_PL: pass = !n;
         COND_VS: pass = v;
         COND_VC: pass = !v;
         COND_HI: pass = c && !z;
         COND_LS: pass = !c || z;
         COND_GE: pass = (n == v);
         COND_LT: pass = (n != v);
         COND_GT: pass = !z && (n == v);
         COND_LE: pass = z || (n != v);
         COND_AL: pass = 1'b1;
         COND_NV: pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_condition_unit.sv
// Conditional branch resolver with flag-write interlock.
// Optional macro BRANCH_STATS_EN builds saturating taken/not-taken counters.
module branch_condition_unit
   import branch_pkg::*;
#(
   parameter int ADDR_WIDTH   = 32,
   parameter int OFFSET_WIDTH = 11,
   parameter int FLAG_LATENCY = 1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    flush,
   input  logic                    flag_update_issued,
   input  logic                    negative_flag,
   input  logic                    zero_flag,
   input  logic                    carry_flag,
   input  logic                    overflow_flag,
   input  logic                    branch_valid,
   output logic                    branch_ready,
   input  logic [3:0]              branch_cond,
   input  logic [ADDR_WIDTH-1:0]   branch_pc,
   input  logic [OFFSET_WIDTH-1:0] branch_offset,
   output logic                    stall,
   output logic                    result_valid,
   output logic                    result_taken,
   output logic [ADDR_WIDTH-1:0]   result_target,
   output logic [STAT_WIDTH-1:0]   stat_taken,
   output logic [STAT_WIDTH-1:0]   stat_not_taken
);

   localparam logic [2:0] LAT = 3'(FLAG_LATENCY);

   state_t                  state;
   logic [2:0]              hazard_cnt;
   logic [3:0]              br_cond;
   logic [ADDR_WIDTH-1:0]   br_pc;
   logic [OFFSET_WIDTH-1:0] br_offset;
   logic [ADDR_WIDTH-1:0]   offset_ext;
   logic [ADDR_WIDTH-1:0]   offset_sh;
   logic [ADDR_WIDTH-1:0]   target_next;
   logic                    pass;
   logic                    accept;
   logic                    flags_clear;
   logic                    resolve_fire;

   assign accept       = branch_valid && branch_ready;
   assign flags_clear  = (hazard_cnt == 3'd0) && !flag_update_issued;
   assign resolve_fire = (state == ST_RESOLVE) && !flush;

   assign offset_ext = {{(ADDR_WIDTH-OFFSET_WIDTH){br_offset[OFFSET_WIDTH-1]}},
                        br_offset};
   assign offset_sh   = offset_ext << 1;
   assign target_next = br_pc + ADDR_WIDTH'(4) + offset_sh;

   cond_evaluator u_cond (
      .cond (br_cond),
      .n    (negative_flag),
      .z    (zero_flag),
      .c    (carry_flag),
      .v    (overflow_flag),
      .pass (pass)
   );

   // Cycles remaining until the last issued flag write is visible
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hazard_cnt <= 3'd0;
      end else if (flag_update_issued) begin
         hazard_cnt <= LAT;
      end else if (hazard_cnt != 3'd0) begin
         hazard_cnt <= hazard_cnt - 3'd1;
      end
   end

   // Branch FSM with registered handshake, stall and result outputs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state         <= ST_IDLE;
         branch_ready  <= 1'b1;
         stall         <= 1'b0;
         result_valid  <= 1'b0;
         result_taken  <= 1'b0;
         result_target <= '0;
         br_cond       <= 4'd0;
         br_pc         <= '0;
         br_offset     <= '0;
      end else begin
         result_valid <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (accept && !flush) begin
                  br_cond      <= branch_cond;
                  br_pc        <= branch_pc;
                  br_offset    <= branch_offset;
                  branch_ready <= 1'b0;
                  if (flags_clear) begin
                     state <= ST_RESOLVE;
                  end else begin
                     state <= ST_WAIT;
                     stall <= 1'b1;
                  end
               end
            end
            ST_WAIT: begin
               if (flush) begin
                  state        <= ST_IDLE;
                  branch_ready <= 1'b1;
                  stall        <= 1'b0;
               end else if (flags_clear) begin
                  state <= ST_RESOLVE;
                  stall <= 1'b0;
               end
            end
            ST_RESOLVE: begin
               state        <= ST_IDLE;
               branch_ready <= 1'b1;
               if (!flush) begin
                  result_valid  <= 1'b1;
                  result_taken  <= pass;
                  result_target <= target_next;
               end
            end
            default: begin
               state        <= ST_IDLE;
               branch_ready <= 1'b1;
               stall        <= 1'b0;
            end
         endcase
      end
   end

`ifdef BRANCH_STATS_EN
   logic [STAT_WIDTH-1:0] taken_count;
   logic [STAT_WIDTH-1:0] not_taken_count;

   // Saturating decision counters, stepped as each result is issued
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         taken_count     <= '0;
         not_taken_count <= '0;
      end else if (resolve_fire) begin
         if (pass) begin
            if (taken_count != '1) taken_count <= taken_count + 1'b1;
         end else begin
            if (not_taken_count != '1) not_taken_count <= not_taken_count + 1'b1;
         end
      end
   end

   assign stat_taken     = taken_count;
   assign stat_not_taken = not_taken_count;
`else
   logic unused_fire;
   assign unused_fire    = resolve_fire;
   assign stat_taken     = '0;
   assign stat_not_taken = '0;
`endif

endmodule
